// File: rtl/shift_sequencer.sv
// Variable-amount (0..2**CNT_W-1) shifter built by iterating a single-position
// shift step once per clock; result, carry and zero flag are published with a DONE pulse.

module shift_sequencer_step #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] din_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             cout_o
);
  always_comb begin
    dout_o = din_i;
    cout_o = 1'b0;
    case (mode_i)
      2'b00: begin dout_o = {1'b0, din_i[WIDTH-1:1]};           cout_o = din_i[0];       end
      2'b01: begin dout_o = {din_i[WIDTH-2:0], 1'b0};           cout_o = din_i[WIDTH-1]; end
      2'b10: begin dout_o = {din_i[WIDTH-1], din_i[WIDTH-1:1]}; cout_o = din_i[0];       end
      2'b11: begin dout_o = {din_i[0], din_i[WIDTH-1:1]};       cout_o = din_i[0];       end
      default: ;
    endcase
  end
endmodule

module shift_sequencer #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [CNT_W-1:0] AMT,
  input  logic [1:0]       MODE,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Y,
  output logic             C,
  output logic             Z
);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             c_q, c_d, z_q, z_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic [WIDTH-1:0] step_y;
  logic             step_c;
  logic             last_step;

  shift_sequencer_step #(.WIDTH(WIDTH)) u_step (
    .din_i  (work_q),
    .mode_i (mode_q),
    .dout_o (step_y),
    .cout_o (step_c)
  );

  assign last_step = (cnt_q == CNT_W'(1));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      y_q     <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      y_q     <= y_d;
      c_q     <= c_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (START) state_d = (AMT != '0) ? S_SHIFT : S_DONE;
      S_SHIFT: if (last_step) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Results load on the edge entering DONE, so they come straight from the
  // final step (or the operand itself when the amount is zero).
  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    y_d    = y_q;
    c_d    = c_q;
    z_d    = z_q;
    case (state_q)
      S_IDLE: if (START) begin
        work_d = A;
        cnt_d  = AMT;
        mode_d = MODE;
        if (AMT == '0) begin
          y_d = A;
          c_d = 1'b0;
          z_d = (A == '0);
        end
      end
      S_SHIFT: begin
        work_d = step_y;
        cnt_d  = cnt_q - CNT_W'(1);
        if (last_step) begin
          y_d = step_y;
          c_d = step_c;
          z_d = (step_y == '0);
        end
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign Y    = y_q;
  assign C    = c_q;
  assign Z    = z_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: each task drives one scenario and checks
// latency, BUSY/DONE framing and the Y/C/Z result against hand-computed values.

module tb_shift_sequencer;
  logic       CLK = 1'b0;
  logic       RST_N, START;
  logic [5:0] A;
  logic [2:0] AMT;
  logic [1:0] MODE;
  logic       BUSY, DONE, C, Z;
  logic [5:0] Y;

  int total = 0;
  int bad = 0;
  logic [5:0] last_y = 6'b0;

  shift_sequencer #(.WIDTH(6), .CNT_W(3)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .A(A), .AMT(AMT), .MODE(MODE),
    .BUSY(BUSY), .DONE(DONE), .Y(Y), .C(C), .Z(Z)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [5:0] a, input logic [2:0] amt, input logic [1:0] mode);
    @(negedge CLK);
    START = 1'b1; A = a; AMT = amt; MODE = mode;
  endtask

  // Waits (bounded) for DONE; lat=0 means it never came.
  task automatic wait_done(input logic [5:0] prev_y, output int lat, output bit busy_ok, output bit y_held);
    lat = 0; busy_ok = 1'b1; y_held = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      START = 1'b0;
      if (BUSY !== 1'b1) busy_ok = 1'b0;
      if (DONE === 1'b1) begin lat = i; break; end
      if (Y !== prev_y) y_held = 1'b0;
    end
  endtask

  task automatic test_reset;
    RST_N = 1'b0; START = 1'b1; A = 6'b111111; AMT = 3'd2; MODE = 2'b00;
    repeat (2) @(negedge CLK);
    START = 1'b0;
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", BUSY); end
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", DONE); end
    total++; if (Y !== 6'b0) begin bad++; $display("FAIL rst_y got=%b exp=000000", Y); end
    total++; if (C !== 1'b0) begin bad++; $display("FAIL rst_c got=%b exp=0", C); end
    total++; if (Z !== 1'b1) begin bad++; $display("FAIL rst_z got=%b exp=1", Z); end
    RST_N = 1'b1;
    @(negedge CLK);
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rst_prio_busy got=%b exp=0", BUSY); end
    last_y = 6'b0;
  endtask

  task automatic test_srl;
    int lat; bit bo, yh;
    issue(6'b101101, 3'd3, 2'b00);
    wait_done(last_y, lat, bo, yh);
    total++; if (lat !== 4) begin bad++; $display("FAIL srl_lat got=%0d exp=4", lat); end
    total++; if (bo !== 1'b1) begin bad++; $display("FAIL srl_busy got=%b exp=1", bo); end
    total++; if (yh !== 1'b1) begin bad++; $display("FAIL srl_y_held got=%b exp=1", yh); end
    total++; if (Y !== 6'b000101) begin bad++; $display("FAIL srl_y got=%b exp=000101", Y); end
    total++; if (C !== 1'b1) begin bad++; $display("FAIL srl_c got=%b exp=1", C); end
    total++; if (Z !== 1'b0) begin bad++; $display("FAIL srl_z got=%b exp=0", Z); end
    last_y = 6'b000101;
    @(negedge CLK);
    total++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin bad++; $display("FAIL srl_after got=%b%b exp=00", DONE, BUSY); end
    total++; if (Y !== 6'b000101) begin bad++; $display("FAIL srl_hold got=%b exp=000101", Y); end
  endtask

  task automatic test_sra;
    int lat; bit bo, yh;
    issue(6'b100100, 3'd2, 2'b10);
    wait_done(last_y, lat, bo, yh);
    total++; if (lat !== 3) begin bad++; $display("FAIL sra_lat got=%0d exp=3", lat); end
    total++; if (bo !== 1'b1 || yh !== 1'b1) begin bad++; $display("FAIL sra_frame got=%b%b exp=11", bo, yh); end
    total++; if (Y !== 6'b111001) begin bad++; $display("FAIL sra_y got=%b exp=111001", Y); end
    total++; if (C !== 1'b0 || Z !== 1'b0) begin bad++; $display("FAIL sra_cz got=%b%b exp=00", C, Z); end
    last_y = 6'b111001;
  endtask

  task automatic test_sll_big;
    int lat; bit bo, yh;
    issue(6'b110001, 3'd7, 2'b01);
    wait_done(last_y, lat, bo, yh);
    total++; if (lat !== 8) begin bad++; $display("FAIL sll7_lat got=%0d exp=8", lat); end
    total++; if (bo !== 1'b1 || yh !== 1'b1) begin bad++; $display("FAIL sll7_frame got=%b%b exp=11", bo, yh); end
    total++; if (Y !== 6'b0) begin bad++; $display("FAIL sll7_y got=%b exp=000000", Y); end
    total++; if (C !== 1'b0 || Z !== 1'b1) begin bad++; $display("FAIL sll7_cz got=%b%b exp=01", C, Z); end
    last_y = 6'b0;
  endtask

  task automatic test_ror_zero;
    int lat; bit bo, yh;
    issue(6'b000011, 3'd1, 2'b11);
    wait_done(last_y, lat, bo, yh);
    total++; if (lat !== 2) begin bad++; $display("FAIL ror_lat got=%0d exp=2", lat); end
    total++; if (Y !== 6'b100001) begin bad++; $display("FAIL ror_y got=%b exp=100001", Y); end
    total++; if (C !== 1'b1 || Z !== 1'b0) begin bad++; $display("FAIL ror_cz got=%b%b exp=10", C, Z); end
    last_y = 6'b100001;
    issue(6'b010101, 3'd0, 2'b00);
    wait_done(last_y, lat, bo, yh);
    total++; if (lat !== 1) begin bad++; $display("FAIL amt0_lat got=%0d exp=1", lat); end
    total++; if (bo !== 1'b1) begin bad++; $display("FAIL amt0_busy got=%b exp=1", bo); end
    total++; if (Y !== 6'b010101) begin bad++; $display("FAIL amt0_y got=%b exp=010101", Y); end
    total++; if (C !== 1'b0 || Z !== 1'b0) begin bad++; $display("FAIL amt0_cz got=%b%b exp=00", C, Z); end
    last_y = 6'b010101;
  endtask

  task automatic test_handshake;
    int lat; bit bo, yh;
    issue(6'b000001, 3'd4, 2'b01);                        // cycle k
    @(negedge CLK); START = 1'b0;                          // k+1
    @(negedge CLK); START = 1'b1; A = 6'b111111; AMT = 3'd7; MODE = 2'b00;  // k+2
    @(negedge CLK); START = 1'b0;                          // k+3
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL hs_busy got=%b exp=1", BUSY); end
    @(negedge CLK);                                        // k+4
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL hs_early_done got=%b exp=0", DONE); end
    total++; if (Y !== last_y) begin bad++; $display("FAIL hs_y_held got=%b exp=%b", Y, last_y); end
    @(negedge CLK);                                        // k+5
    total++; if (DONE !== 1'b1) begin bad++; $display("FAIL hs_done got=%b exp=1", DONE); end
    total++; if (Y !== 6'b010000 || C !== 1'b0) begin bad++; $display("FAIL hs_y got=%b c=%b exp=010000 c=0", Y, C); end
    START = 1'b1; A = 6'b111111; AMT = 3'd1; MODE = 2'b01;
    @(negedge CLK);                                        // k+6
    total++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin bad++; $display("FAIL hs_idle got=%b%b exp=00", DONE, BUSY); end
    total++; if (Y !== 6'b010000) begin bad++; $display("FAIL hs_ignore got=%b exp=010000", Y); end
    last_y = 6'b010000;
    A = 6'b000011; AMT = 3'd1; MODE = 2'b11;
    wait_done(last_y, lat, bo, yh);
    total++; if (lat !== 2) begin bad++; $display("FAIL hs_next_lat got=%0d exp=2", lat); end
    total++; if (Y !== 6'b100001 || C !== 1'b1) begin bad++; $display("FAIL hs_next_y got=%b c=%b exp=100001 c=1", Y, C); end
    last_y = 6'b100001;
  endtask

  task automatic test_reset_mid;
    int lat; bit bo, yh, seen;
    issue(6'b111111, 3'd5, 2'b00);                         // k
    @(negedge CLK); START = 1'b0;                          // k+1
    @(negedge CLK);                                        // k+2
    @(negedge CLK); RST_N = 1'b0;                          // k+3
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL rm_busy_pre got=%b exp=1", BUSY); end
    @(negedge CLK);                                        // k+4
    total++; if (Y !== 6'b0 || C !== 1'b0 || Z !== 1'b1) begin bad++; $display("FAIL rm_out got=%b c=%b z=%b exp=000000 c=0 z=1", Y, C, Z); end
    total++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin bad++; $display("FAIL rm_flags got=%b%b exp=00", BUSY, DONE); end
    RST_N = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (DONE === 1'b1) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rm_no_done got=%b exp=0", seen); end
    last_y = 6'b0;
    issue(6'b111111, 3'd2, 2'b00);
    wait_done(last_y, lat, bo, yh);
    total++; if (lat !== 3) begin bad++; $display("FAIL rm_new_lat got=%0d exp=3", lat); end
    total++; if (Y !== 6'b001111 || C !== 1'b1 || Z !== 1'b0) begin bad++; $display("FAIL rm_new_y got=%b c=%b z=%b exp=001111 c=1 z=0", Y, C, Z); end
  endtask

  initial begin
    RST_N = 1'b0; START = 1'b0; A = '0; AMT = '0; MODE = '0;
    test_reset();
    test_srl();
    test_sra();
    test_sll_big();
    test_ror_zero();
    test_handshake();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller that sequences the team's single-position 6-bit shift datapath to perform variable-amount shifts (0-7 positions).
- Captures an operand, shift amount and mode on a START handshake, then applies one 1-bit shift step per clock.
- Reports the result with carry-out and zero flags on a one-cycle DONE pulse.
- Sits between the ALU control decoder and the ALU result mux, in place of the fixed 1-bit shift path.

Parameters:
- WIDTH, 6, operand/result width in bits.
- CNT_W, 3, shift-amount width; maximum amount is 2**CNT_W-1.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  synchronous reset, active-low.
- START  in  1  request. Sampled only in IDLE.
- A  in  WIDTH  operand, captured on accept.
- AMT  in  CNT_W  shift amount, captured on accept.
- MODE  in  2  operation select, captured on accept: 00 SRL, 01 SLL, 10 SRA, 11 ROR.
- BUSY  out  1  high while an operation is in progress (states SHIFT and DONE).
- DONE  out  1  one-cycle pulse; Y, C and Z are valid and held from this cycle.
- Y  out  WIDTH  result register.
- C  out  1  last bit shifted out (for ROR: last bit rotated to the MSB); 0 if AMT=0.
- Z  out  1  high when Y equals 0.

Behaviour:
- Interface: one clock CLK; reset RST_N is synchronous and active-low. All outputs are registered.
- Reset values (RST_N=0 at a rising edge): state IDLE, BUSY=0, DONE=0, Y=0, C=0, Z=1, internal working register=0, counter=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if START=1, latch A into the working register, AMT into the counter, and MODE; clear the internal carry.
  - Next state is SHIFT if AMT≠0, otherwise DONE.
- SHIFT: each cycle apply one step to the working register and load the carry with the bit that leaves, then decrement the counter.
  - SRL: shift right, MSB filled with 0, carry = bit0.
  - SLL: shift left, LSB filled with 0, carry = bit WIDTH-1.
  - SRA: shift right, MSB replicates the sign bit, carry = bit0.
  - ROR: rotate right, bit0 moves to the MSB, carry = bit0.
  - When the counter equals 1, the next state is DONE.
- DONE: copy the working register to Y and the carry to C; Z = (working register == 0); DONE=1 for exactly this cycle; next state is IDLE.
  - Implementation requirement: Y, C and Z are updated on the edge entering DONE so that they are valid while DONE=1.
- Latency: with START accepted at cycle k, DONE=1 in cycle k+1+AMT. BUSY=1 in cycles k+1 through k+1+AMT.
- Y, C and Z change only on the edge entering DONE. They hold their values until the next operation completes, and do not show intermediate shift steps.
- START while BUSY=1 is ignored: no queuing and no effect on the operation in progress.
- START in the same cycle as DONE=1 is ignored. The earliest accepted START is the first IDLE cycle after DONE.
- Amounts ≥ WIDTH need no special-case logic; iteration gives the results directly:
  - SRL and SLL produce 0.
  - SRA produces all sign bits.
  - ROR wraps modulo WIDTH.
- Inputs A, AMT and MODE are don't-care outside the accept cycle.
- Reset mid-operation: the operation aborts with no DONE pulse. All outputs return to reset values on that edge, and the state is IDLE on the following cycle.
- RST_N=0 takes priority over START in the same cycle.

Test Plan:
- SRL: A=6'b101101, AMT=3, START at cycle k -> DONE at k+4, Y=6'b000101, C=1, Z=0. BUSY high for cycles k+1..k+4.
- SRA: A=6'b100100, AMT=2 -> DONE at k+3, Y=6'b111001, C=0, Z=0.
- SLL with amount > WIDTH: A=6'b110001, AMT=7 -> DONE at k+8, Y=0, C=0, Z=1.
- ROR and AMT=0:
  - ROR, A=6'b000011, AMT=1 -> DONE at k+2, Y=6'b100001, C=1.
  - SRL, A=6'b010101, AMT=0 -> DONE at k+1, Y=6'b010101, C=0.
- Handshake: start SLL A=6'b000001 AMT=4. Pulse START with A=6'b111111 at k+2 and again in the DONE cycle (k+5) -> both ignored; DONE only at k+5 with Y=6'b010000, C=0. A START at k+6 is accepted.
- Reset mid-operation: SRL A=6'b111111 AMT=5, RST_N=0 at k+3 -> at k+4 Y=0, C=0, Z=1, BUSY=0. No DONE pulse ever appears. A new START after reset completes normally.
